// File: rtl/tc_filerom_streamer.sv
// Walks a file ROM: reads the length at address all-ones, then streams 8-byte
// little-endian words from a byte offset through a small FIFO with keep/last flags.
module tc_filerom_streamer #(
  parameter int          DEPTH     = 4,
  parameter logic [63:0] MAX_BYTES = 64'd65536
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [63:0] base,
  output logic        rom_en,
  output logic [63:0] rom_address,
  input  logic [63:0] rom_data,
  output logic        m_valid,
  input  logic        m_ready,
  output logic [63:0] m_data,
  output logic [7:0]  m_keep,
  output logic        m_last,
  output logic        busy,
  output logic        done,
  output logic [63:0] file_size
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] SIZE   = 3'd1;
  localparam logic [2:0] FETCH  = 3'd2;
  localparam logic [2:0] DRAIN  = 3'd3;
  localparam logic [2:0] FINISH = 3'd4;

  // Current FSM state; kept as a plain named signal so checkers can bind to it.
  logic [2:0]    state;
  logic [63:0]   base_q;
  logic [63:0]   remaining;
  logic [AW:0]   count;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  logic [63:0] mem_data [DEPTH];
  logic [7:0]  mem_keep [DEPTH];
  logic        mem_last [DEPTH];

  logic [63:0] size_clamp;
  logic        push;
  logic        pop;
  logic [7:0]  push_keep;
  logic        push_last;
  logic [63:0] step;

  // Handshake: a word transfers on a rising edge where m_valid and m_ready are
  // both high; m_valid never depends on m_ready and the head holds until taken.
  always_comb begin
    size_clamp = (rom_data > MAX_BYTES) ? MAX_BYTES : rom_data;
    push       = (state == FETCH) && (count < FULL_CNT);
    pop        = m_valid && m_ready;
    push_last  = (remaining <= 64'd8);
    push_keep  = (remaining >= 64'd8) ? 8'hFF : ((8'd1 << remaining[2:0]) - 8'd1);
    step       = push_last ? remaining : 64'd8;
  end

  assign rom_en  = (state == SIZE) || (state == FETCH);
  assign m_valid = (count != '0);
  assign m_data  = m_valid ? mem_data[rd_ptr] : 64'd0;
  assign m_keep  = m_valid ? mem_keep[rd_ptr] : 8'd0;
  assign m_last  = m_valid ? mem_last[rd_ptr] : 1'b0;

  // Storage has no reset; occupancy is tracked by count and the outputs are gated.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_data[wr_ptr] <= rom_data;
      mem_keep[wr_ptr] <= push_keep;
      mem_last[wr_ptr] <= push_last;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      rom_address <= 64'd0;
      busy        <= 1'b0;
      done        <= 1'b0;
      file_size   <= 64'd0;
      base_q      <= 64'd0;
      remaining   <= 64'd0;
      count       <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            base_q      <= base;
            busy        <= 1'b1;
            rom_address <= '1;
            state       <= SIZE;
          end
        end
        SIZE: begin
          file_size <= size_clamp;
          if (base_q < size_clamp) begin
            remaining   <= size_clamp - base_q;
            rom_address <= base_q;
            state       <= FETCH;
          end else begin
            remaining <= 64'd0;
            done      <= 1'b1;
            state     <= FINISH;
          end
        end
        FETCH: begin
          if (push) begin
            rom_address <= rom_address + 64'd8;
            remaining   <= remaining - step;
            if (push_last) state <= DRAIN;
          end
        end
        DRAIN: begin
          if (pop && m_last) begin
            done  <= 1'b1;
            state <= FINISH;
          end
        end
        FINISH: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase

      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule
